rr_mux_arbiter: RTL and testbench
=================================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter and sequencer for an 8:1 one-bit selection datapath. Eight requesters share a single output channel.
- The block picks one requester and drives the 3-bit select. It presents the selected data bit on a valid/ready output and holds the grant for a bounded burst.
- It sits between the requester array and the downstream consumer. The select mux is internal.

Parameters:
- N_REQ, 8, number of requesters. Fixed at 8 in this revision.
- SEL_W, 3, select width, equal to clog2(N_REQ).
- MAX_HOLD, 4, maximum accepted beats per grant before forced rotation. Legal range 1..15.
- CNT_W, 4, burst counter width. Must hold MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable. Low blocks new grants only.
- req  input  8  per-requester request. Level, held until served.
- in  input  8  per-requester data bit. in[i] belongs to requester i.
- gnt  output  8  one-hot grant, registered.
- sel  output  3  current select, registered. Equals the index of gnt.
- y  output  1  selected data, in[sel]. Forced to 0 when out_valid is 0.
- out_valid  output  1  beat available to the consumer.
- out_ready  input  1  consumer accepts the beat.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, ptr=0, sel=0, gnt=0, beat_cnt=0.
  - busy=0, out_valid=0, y=0.
  - If reset asserts mid-burst, the burst is dropped. No beat is counted as accepted.
- States: IDLE, BUSY.
- Pick function: first i in order ptr, ptr+1, ..., ptr+7 (mod 8) with req[i]=1.
- IDLE:
  - If en and |req: register gnt=onehot(pick), sel=pick, beat_cnt=0, go to BUSY.
  - Arbitration latency is 1 cycle from req assertion to gnt/out_valid.
  - Otherwise stay in IDLE.
- BUSY:
  - out_valid = req[sel].
  - y = in[sel] when out_valid, else 0. This path is combinational from the registered sel.
  - busy=1.
  - A beat is accepted when out_valid & out_ready. On acceptance, beat_cnt increments.
- Release conditions, evaluated every BUSY cycle:
  - (a) req[sel]=0. The requester withdrew; release even if no beat was accepted.
  - (b) A beat is accepted and beat_cnt == MAX_HOLD-1.
- On release:
  - ptr <= sel+1 (mod 8, 3-bit wrap from 7 to 0).
  - If en and any req is set, re-arbitrate in the same cycle using the new ptr. The next cycle has the new gnt, so there is no bubble.
  - With the rotated ptr, the released requester has lowest priority. It is re-granted back-to-back only if it is the sole requester.
  - Otherwise go to IDLE with gnt=0.
- en low during BUSY: the current grant runs to release. No new grant is issued until en=1.
- Stall: out_ready=0 with out_valid=1 holds sel, y path and beat_cnt. There is no timeout.
- gnt is always one-hot or zero, and sel is stable for the whole grant.
- req[i] for an ungranted requester never affects the current burst.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state enum {IDLE, BUSY}
  - N_REQ and SEL_W constants
  - onehot-from-index function
- One natural sub-module, rr_pick8. It is combinational: it takes req[7:0] and ptr[2:0] and returns found and idx[2:0]. It is built with a doubled-vector rotate plus a priority encode.
- The FSM, counters and y-select live in the top.

Test Plan:
- Reset then single requester:
  - Stimulus: req=8'h04, in=8'h04, out_ready=1.
  - Response: cycle+1 gnt=8'h04, sel=2, out_valid=1, y=1. After 4 accepted beats, release. ptr=3, then re-grant to 2 with no idle cycle.
- All requesting, out_ready=1, MAX_HOLD=4:
  - Response: grants rotate 0,1,2,...,7,0. Each grant lasts exactly 4 beats. Check ptr wrap from 7 to 0.
- Withdrawal:
  - Stimulus: req=8'h81, grant to 0, then drop req[0] after 1 beat.
  - Response: out_valid=0 that cycle, next cycle gnt=8'h80, sel=7.
- Backpressure:
  - Stimulus: granted 5, out_ready=0 for 6 cycles, then 1.
  - Response: sel=5 held, beat_cnt frozen, burst completes after 4 accepted beats.
- en gating:
  - Stimulus: en=0 while req=8'hFF in IDLE.
  - Response: gnt stays 0, out_valid=0. Set en=1: next cycle gnt=onehot(ptr). Drop en mid-burst: the burst finishes, then IDLE.
- Async reset mid-burst:
  - Stimulus: assert rst_n=0 between clock edges during BUSY.
  - Response: gnt, sel, out_valid, y and busy are 0 immediately. After release, the first grant starts from ptr=0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick8.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_REQ-1:0] doubled;
    logic [N_REQ-1:0]   rotated;
    logic [SEL_W-1:0]   offset;

    always_comb begin
        // Shifting the doubled vector puts requester ptr at bit 0.
        doubled = {req, req} >> ptr;
        rotated = doubled[N_REQ-1:0];
        offset  = '0;
        found   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SEL_W'(i);
                found  = 1'b1;
            end
        end
        idx = ptr + offset;
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight one-bit requesters sharing a valid/ready
// output channel, with a bounded burst length per grant.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    state_t           state, state_nx;
    logic [SEL_W-1:0] ptr, ptr_nx, sel_nx;
    logic [N_REQ-1:0] gnt_nx;
    logic [CNT_W-1:0] beat_cnt, cnt_nx;
    logic [SEL_W-1:0] pick_ptr, pick_idx;
    logic             pick_found;
    logic             accept, last_beat, rel;

    assign busy      = (state == BUSY);
    assign out_valid = busy & req[sel];
    assign y         = out_valid & in[sel];
    assign accept    = out_valid & out_ready;
    assign last_beat = (beat_cnt == CNT_W'(MAX_HOLD - 1));
    assign rel       = busy & (~req[sel] | (accept & last_beat));

    // While busy, search from the rotated pointer so a release can re-grant
    // in the same cycle with the releasing requester at lowest priority.
    assign pick_ptr  = busy ? sel + 1'b1 : ptr;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = gnt;
        cnt_nx   = beat_cnt;
        case (state)
            IDLE: begin
                if (en && pick_found) begin
                    state_nx = BUSY;
                    sel_nx   = pick_idx;
                    gnt_nx   = onehot(pick_idx);
                    cnt_nx   = '0;
                end
            end
            BUSY: begin
                if (accept) cnt_nx = beat_cnt + 1'b1;
                if (rel) begin
                    ptr_nx = pick_ptr;
                    cnt_nx = '0;
                    if (en && pick_found) begin
                        sel_nx = pick_idx;
                        gnt_nx = onehot(pick_idx);
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            gnt      <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            sel      <= sel_nx;
            gnt      <= gnt_nx;
            beat_cnt <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter against a per-cycle behavioural model.
module tb_rr_mux_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       y;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int tests = 0;
    int fails = 0;

    // Behavioural model: who holds the channel, how many beats it has had,
    // and where the next round-robin search starts.
    bit m_busy;
    int m_sel;
    int m_ptr;
    int m_cnt;

    rr_mux_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .in        (din),
        .gnt       (gnt),
        .sel       (sel),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic m_rst();
        m_busy = 0;
        m_sel  = 0;
        m_ptr  = 0;
        m_cnt  = 0;
    endtask

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        bit acc;
        bit rel;
        @(posedge clk);
        if (!rst_n) begin
            m_rst();
        end else if (!m_busy) begin
            if (en && req != 8'h00) begin
                m_sel  = pick(req, m_ptr);
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            acc = req[m_sel] && out_ready;
            if (acc) m_cnt++;
            rel = !req[m_sel] || (acc && m_cnt == MAX_HOLD);
            if (rel) begin
                m_ptr = (m_sel + 1) % 8;
                m_cnt = 0;
                if (en && req != 8'h00) m_sel = pick(req, m_ptr);
                else m_busy = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req       = 8'h00;
        din       = 8'h00;
        out_ready = 1'b0;
        m_rst();
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req       = 8'h00;
        din       = 8'h00;
        out_ready = 1'b0;
        m_rst();
        tick();
        tick();
        tests++;
        if (gnt !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || y !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got gnt=%h sel=%0d vld=%b y=%b busy=%b expected all zero",
                     gnt, sel, out_valid, y, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got gnt=%h busy=%b expected 00/0", gnt, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        en = 1'b1; req = 8'h04; din = 8'h04; out_ready = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h04 || sel !== 3'd2 || out_valid !== 1'b1 || y !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: got gnt=%h sel=%0d vld=%b y=%b expected 04/2/1/1",
                     gnt, sel, out_valid, y);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h04 || busy !== 1'b1 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL single_regrant c%0d: got gnt=%h busy=%b vld=%b expected 04/1/1",
                         c, gnt, busy, out_valid);
            end
        end
        din = 8'h00;
        #1;
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL single_y_data: got y=%b expected 0", y);
        end
    endtask

    task automatic test_rotate();
        int  prev;
        int  run_len;
        bit  seen_wrap;
        bit  ev;
        do_reset();
        en = 1'b1; req = 8'hFF; out_ready = 1'b1;
        prev = -1; run_len = 0; seen_wrap = 0;
        for (int c = 0; c < 44; c++) begin
            din = 8'($urandom);
            tick();
            ev = m_busy && req[m_sel];
            tests++;
            if (gnt !== (m_busy ? 8'(1 << m_sel) : 8'h00) || busy !== m_busy || out_valid !== ev ||
                y !== (ev && din[m_sel]) || (m_busy && sel !== 3'(m_sel))) begin
                fails++;
                $display("FAIL rotate_model c%0d: got gnt=%h sel=%0d vld=%b y=%b expected sel=%0d busy=%b",
                         c, gnt, sel, out_valid, y, m_sel, m_busy);
            end
            if (prev >= 0 && int'(sel) != prev) begin
                tests++;
                if (int'(sel) != (prev + 1) % 8 || run_len != MAX_HOLD) begin
                    fails++;
                    $display("FAIL rotate_order: got sel=%0d after %0d held %0d cycles expected sel=%0d held %0d",
                             sel, prev, run_len, (prev + 1) % 8, MAX_HOLD);
                end
                if (prev == 7 && sel == 3'd0) seen_wrap = 1;
                run_len = 0;
            end
            prev = int'(sel);
            run_len++;
        end
        tests++;
        if (!seen_wrap) begin
            fails++;
            $display("FAIL rotate_wrap: got no 7->0 transition expected one");
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        en = 1'b1; req = 8'h81; din = 8'hFF; out_ready = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h01) begin
            fails++;
            $display("FAIL withdraw_first: got gnt=%h expected 01", gnt);
        end
        tick();
        req = 8'h80;
        #1;
        tests++;
        if (out_valid !== 1'b0 || y !== 1'b0) begin
            fails++;
            $display("FAIL withdraw_valid: got vld=%b y=%b expected 0/0", out_valid, y);
        end
        tick();
        tests++;
        if (gnt !== 8'h80 || sel !== 3'd7 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL withdraw_next: got gnt=%h sel=%0d vld=%b expected 80/7/1", gnt, sel, out_valid);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        en = 1'b1; req = 8'h20; din = 8'h20; out_ready = 1'b0;
        tick();
        tests++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            fails++;
            $display("FAIL bp_grant: got gnt=%h sel=%0d expected 20/5", gnt, sel);
        end
        req = 8'h21;
        for (int c = 0; c < 6; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h20 || sel !== 3'd5 || out_valid !== 1'b1 || y !== 1'b1) begin
                fails++;
                $display("FAIL bp_stall c%0d: got gnt=%h sel=%0d vld=%b y=%b expected 20/5/1/1",
                         c, gnt, sel, out_valid, y);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h20) begin
                fails++;
                $display("FAIL bp_beats c%0d: got gnt=%h expected 20", c, gnt);
            end
        end
        tick();
        tests++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            fails++;
            $display("FAIL bp_release: got gnt=%h sel=%0d expected 01/0", gnt, sel);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        en = 1'b0; req = 8'hFF; din = 8'h00; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h00 || out_valid !== 1'b0) begin
                fails++;
                $display("FAIL en_block c%0d: got gnt=%h vld=%b expected 00/0", c, gnt, out_valid);
            end
        end
        en = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h01) begin
            fails++;
            $display("FAIL en_grant: got gnt=%h expected 01", gnt);
        end
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h01 || busy !== 1'b1) begin
                fails++;
                $display("FAIL en_finish c%0d: got gnt=%h busy=%b expected 01/1", c, gnt, busy);
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (gnt !== 8'h00 || busy !== 1'b0) begin
                fails++;
                $display("FAIL en_idle c%0d: got gnt=%h busy=%b expected 00/0", c, gnt, busy);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; req = 8'hFF; din = 8'hFF; out_ready = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h02) begin
            fails++;
            $display("FAIL areset_pre: got gnt=%h expected 02", gnt);
        end
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (gnt !== 8'h00 || sel !== 3'd0 || out_valid !== 1'b0 || y !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_now: got gnt=%h sel=%0d vld=%b y=%b busy=%b expected all zero",
                     gnt, sel, out_valid, y, busy);
        end
        m_rst();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            fails++;
            $display("FAIL areset_ptr: got gnt=%h sel=%0d expected 01/0", gnt, sel);
        end
    endtask

    task automatic test_random();
        bit ev;
        for (int c = 0; c < 600; c++) begin
            req       = 8'($urandom & $urandom);
            if ($urandom_range(0, 3) == 0) req = 8'($urandom);
            din       = 8'($urandom);
            en        = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            ev = m_busy && req[m_sel];
            tests++;
            if (gnt !== (m_busy ? 8'(1 << m_sel) : 8'h00) || busy !== m_busy || out_valid !== ev ||
                y !== (ev && din[m_sel]) || (m_busy && sel !== 3'(m_sel))) begin
                fails++;
                $display("FAIL random_model c%0d: got gnt=%h sel=%0d vld=%b y=%b expected sel=%0d busy=%b vld=%b",
                         c, gnt, sel, out_valid, y, m_sel, m_busy, ev);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_withdraw();
        test_backpressure();
        test_en_gating();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
